lvds_pll_phase_stepper: RTL and testbench
=========================================

// Module: lvds_pll_phase_stepper
// PURPOSE
//  Initiator for the Cyclone V PLL dynamic-phase-shift (DPS) port: drives phase_en/updn/cntsel,
//  consumes phase_done. Accepts "N steps up/down on counter K" requests from LVDS deskew/training
//  logic and issues them as single-step handshakes to the LVDS input SDR PLL. Runs entirely on scanclk.
// PARAMETERS
//  CNTSEL_W        5     width of counter select (matches PLL cntsel)
//  STEP_W          8     width of step-count request; 0 = no-op
//  PHASE_EN_CYC    2     scanclk cycles phase_en is held high per step (>=2)
//  TIMEOUT_CYC     1024  max cycles waiting on any phase_done edge before error
//  GAP_CYC         2     idle cycles between consecutive steps
// PORTS
//  scanclk      in   1         DPS clock; all logic synchronous to rising edge
//  rst_n        in   1         asynchronous active-low reset
//  req_valid    in   1         request valid
//  req_ready    out  1         request accepted when valid&ready
//  req_cntsel   in   CNTSEL_W  PLL counter to shift
//  req_updn     in   1         1 = shift later (up), 0 = earlier
//  req_steps    in   STEP_W    number of single steps
//  busy         out  1         request in progress
//  done         out  1         1-cycle pulse: request finished (success or error)
//  err_code     out  2         0 none, 1 timeout, 2 lock lost; held until next accept
//  steps_done   out  STEP_W    steps completed in current/last request
//  pll_locked   in   1         PLL locked (async; synchronised internally)
//  phase_en     out  1         to PLL phase_en
//  updn         out  1         to PLL updn
//  cntsel       out  CNTSEL_W  to PLL cntsel
//  phase_done   in   1         from PLL (async; synchronised internally)
// BEHAVIOUR
//  Reset: phase_en=0, updn=0, cntsel=0, busy=0, done=0, err_code=0, steps_done=0, FSM=IDLE.
//  phase_done and pll_locked pass through 2-FF synchronisers (2-cycle latency), used only synced.
//  req_ready = (state==IDLE) & locked_s. On accept: latch cntsel/updn/steps, steps_done=0, err_code=0.
//  FSM:
//   IDLE     : accept -> steps==0 ? DONE : SETUP.
//   SETUP    : cntsel/updn driven, phase_en=0 one cycle (setup before phase_en rise) -> ASSERT.
//   ASSERT   : phase_en=1 for PHASE_EN_CYC cycles -> WAIT_LO.
//   WAIT_LO  : phase_en=0; wait phase_done_s==0 -> WAIT_HI; timeout -> DONE, err_code=1.
//   WAIT_HI  : wait phase_done_s==1 -> steps_done++ ; (steps_done+1==steps) ? DONE : GAP.
//              timeout -> DONE, err_code=1.
//   GAP      : GAP_CYC cycles -> SETUP.
//   DONE     : done=1 one cycle, busy=0 next cycle -> IDLE.
//  Timeout counter clears on every state entry; fires when count reaches TIMEOUT_CYC-1.
//  cntsel/updn stable from SETUP through WAIT_HI; never change while phase_en=1.
//  locked_s falling in any non-IDLE state except DONE: drop phase_en immediately, -> DONE,
//   err_code=2; steps_done keeps value reached (partial shift is reported, not rolled back).
//  Simultaneous timeout and lock loss in same cycle: err_code=2 wins.
//  busy=1 from accept cycle+1 through DONE cycle.
//  req_valid while busy: ignored (ready=0); requester must hold valid.
//  Reset mid-step: async clear; PLL may complete an in-flight step untracked.
//  steps_done saturates never: bounded by latched req_steps (STEP_W bits, no wrap).
// STRUCTURE
//  Shared pkg lvds_pll_pkg: err_code localparams (ERR_NONE/ERR_TIMEOUT/ERR_LOCK), FSM state enum,
//  DPS timing constants (PHASE_EN_CYC, GAP_CYC defaults).
//  Sub-module: lvds_sync_2ff (reset-to-0 bit synchroniser), instanced for phase_done and pll_locked.
//  Top holds FSM, step counter, timeout counter.
// TESTING (PLL DPS behavioural model: phase_done low 2 cycles after phase_en rise, high 4 later)
//  1 req cntsel=0 updn=1 steps=3 -> exactly 3 phase_en pulses, each 2 cycles, steps_done=3,
//    done pulse, err_code=0; cntsel=0/updn=1 stable across all pulses.
//  2 req steps=0 -> no phase_en pulse, done 2 cycles after accept, steps_done=0, err_code=0.
//  3 model never drops phase_done, steps=2 -> done after TIMEOUT_CYC wait, err_code=1, steps_done=0.
//  4 steps=5, drop pll_locked after 2nd step completes -> phase_en low within 3 cycles of drop,
//    done, err_code=2, steps_done=2; req_ready=0 until locked restored.
//  5 back-to-back: second req_valid held during first -> accepted only after first done; cntsel=1
//    updn=0 steps=1 -> one pulse, err_code cleared to 0 at accept.
//  6 rst_n asserted in WAIT_HI -> all outputs at reset values immediately (async), FSM IDLE.

Source files
------------

// File: rtl/lvds_pll_pkg.sv
// Shared error codes, FSM states and DPS timing defaults
// for the LVDS PLL dynamic-phase-shift stepper.
package lvds_pll_pkg;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_LOCK    = 2'd2;

    localparam int DPS_CNTSEL_W     = 5;
    localparam int DPS_STEP_W       = 8;
    localparam int DPS_PHASE_EN_CYC = 2;
    localparam int DPS_TIMEOUT_CYC  = 1024;
    localparam int DPS_GAP_CYC      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ASSERT,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_GAP,
        ST_DONE
    } dps_state_t;

endpackage

// File: rtl/lvds_pll_phase_stepper_if.sv
// Step-request and status bundle between deskew/training
// logic (master) and the phase stepper (slave).
interface lvds_pll_phase_stepper_if
    import lvds_pll_pkg::*;
#(
    parameter int CNTSEL_W = DPS_CNTSEL_W,
    parameter int STEP_W   = DPS_STEP_W
);
    logic                req_valid;
    logic                req_ready;
    logic [CNTSEL_W-1:0] req_cntsel;
    logic                req_updn;
    logic [STEP_W-1:0]   req_steps;
    logic                busy;
    logic                done;
    logic [1:0]          err_code;
    logic [STEP_W-1:0]   steps_done;

    modport master (
        output req_valid,
        output req_cntsel,
        output req_updn,
        output req_steps,
        input  req_ready,
        input  busy,
        input  done,
        input  err_code,
        input  steps_done
    );

    modport slave (
        input  req_valid,
        input  req_cntsel,
        input  req_updn,
        input  req_steps,
        output req_ready,
        output busy,
        output done,
        output err_code,
        output steps_done
    );
endinterface

// File: rtl/lvds_sync_2ff.sv
// Two-flop bit synchroniser, clears to 0 on reset.
module lvds_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/lvds_pll_phase_stepper.sv
// Issues N single-step DPS handshakes (phase_en/updn/cntsel,
// phase_done) to the LVDS input PLL per accepted request.
module lvds_pll_phase_stepper
    import lvds_pll_pkg::*;
#(
    parameter int CNTSEL_W     = DPS_CNTSEL_W,
    parameter int STEP_W       = DPS_STEP_W,
    parameter int PHASE_EN_CYC = DPS_PHASE_EN_CYC,
    parameter int TIMEOUT_CYC  = DPS_TIMEOUT_CYC,
    parameter int GAP_CYC      = DPS_GAP_CYC
) (
    input  logic                scanclk,
    input  logic                rst_n,
    lvds_pll_phase_stepper_if.slave req,
    input  logic                pll_locked,
    output logic                phase_en,
    output logic                updn,
    output logic [CNTSEL_W-1:0] cntsel,
    input  logic                phase_done
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] PE_LAST  = TW'(PHASE_EN_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);

    logic              locked_s;
    logic              pd_s;
    dps_state_t        state;
    logic [TW-1:0]     tmo;
    logic [STEP_W-1:0] steps_q;
    logic [STEP_W-1:0] sdone_q;
    logic [STEP_W-1:0] steps_nxt;
    logic              busy_q;
    logic              done_q;
    logic [1:0]        err_q;
    logic              accept;
    logic              lock_lost;
    logic              tmo_hit;

    lvds_sync_2ff u_sync_done (
        .clk   (scanclk),
        .rst_n (rst_n),
        .d     (phase_done),
        .q     (pd_s)
    );

    lvds_sync_2ff u_sync_lock (
        .clk   (scanclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    assign req.req_ready  = (state == ST_IDLE) && locked_s;
    assign req.busy       = busy_q;
    assign req.done       = done_q;
    assign req.err_code   = err_q;
    assign req.steps_done = sdone_q;

    assign accept    = req.req_valid && req.req_ready;
    assign tmo_hit   = (tmo == TMO_LAST);
    assign steps_nxt = sdone_q + 1'b1;

    // DONE is excluded so an error is never overwritten on the way out
    assign lock_lost = !locked_s &&
        (state inside {ST_SETUP, ST_ASSERT, ST_WAIT_LO,
                       ST_WAIT_HI, ST_GAP});

    always_ff @(posedge scanclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tmo      <= '0;
            steps_q  <= '0;
            sdone_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= ERR_NONE;
            phase_en <= 1'b0;
            updn     <= 1'b0;
            cntsel   <= '0;
        end else begin
            done_q <= (state == ST_DONE);
            tmo    <= tmo + 1'b1;
            if (lock_lost) begin
                phase_en <= 1'b0;
                err_q    <= ERR_LOCK;
                tmo      <= '0;
                state    <= ST_DONE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            cntsel  <= req.req_cntsel;
                            updn    <= req.req_updn;
                            steps_q <= req.req_steps;
                            sdone_q <= '0;
                            err_q   <= ERR_NONE;
                            busy_q  <= 1'b1;
                            tmo     <= '0;
                            state   <= (req.req_steps == '0) ?
                                       ST_DONE : ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        phase_en <= 1'b1;
                        tmo      <= '0;
                        state    <= ST_ASSERT;
                    end
                    ST_ASSERT: begin
                        if (tmo == PE_LAST) begin
                            phase_en <= 1'b0;
                            tmo      <= '0;
                            state    <= ST_WAIT_LO;
                        end
                    end
                    ST_WAIT_LO: begin
                        if (!pd_s) begin
                            tmo   <= '0;
                            state <= ST_WAIT_HI;
                        end else if (tmo_hit) begin
                            err_q <= ERR_TIMEOUT;
                            tmo   <= '0;
                            state <= ST_DONE;
                        end
                    end
                    ST_WAIT_HI: begin
                        if (pd_s) begin
                            sdone_q <= steps_nxt;
                            tmo     <= '0;
                            state   <= (steps_nxt == steps_q) ?
                                       ST_DONE : ST_GAP;
                        end else if (tmo_hit) begin
                            err_q <= ERR_TIMEOUT;
                            tmo   <= '0;
                            state <= ST_DONE;
                        end
                    end
                    ST_GAP: begin
                        if (tmo == GAP_LAST) begin
                            tmo   <= '0;
                            state <= ST_SETUP;
                        end
                    end
                    ST_DONE: begin
                        busy_q <= 1'b0;
                        tmo    <= '0;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lvds_pll_phase_stepper.sv
// Directed bench for lvds_pll_phase_stepper with a behavioural
// PLL DPS model (phase_done low 2 cycles after phase_en rise, high 4 later).
module tb_lvds_pll_phase_stepper;
    import lvds_pll_pkg::*;

    logic       scanclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       phase_en;
    logic       updn;
    logic [4:0] cntsel;
    logic       phase_done = 1'b1;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    always #5 scanclk = ~scanclk;
    always @(posedge scanclk) cyc <= cyc + 1;

    lvds_pll_phase_stepper_if #(.CNTSEL_W(5), .STEP_W(8)) bus ();

    lvds_pll_phase_stepper dut (
        .scanclk    (scanclk),
        .rst_n      (rst_n),
        .req        (bus),
        .pll_locked (pll_locked),
        .phase_en   (phase_en),
        .updn       (updn),
        .cntsel     (cntsel),
        .phase_done (phase_done)
    );

    // PLL DPS model
    int   mt = 0;
    logic pe_q = 1'b0;
    bit   model_on = 1'b1;
    always @(posedge scanclk) begin
        if (phase_en && !pe_q) mt = 1;
        else if (mt != 0) mt = mt + 1;
        if (mt == 2 && model_on) phase_done <= 1'b0;
        if (mt == 6) begin
            phase_done <= 1'b1;
            mt = 0;
        end
        pe_q = phase_en;
    end

    // phase_en pulse monitor
    logic [4:0] exp_cs = '0;
    logic       exp_ud = 1'b0;
    int   pe_cnt = 0, run = 0, width_bad = 0, stab_bad = 0;
    int   last_pe_cyc = -1;
    logic [4:0] last_pe_cs = '0;
    logic       last_pe_ud = 1'b0;
    logic       pe_prev = 1'b0;
    always @(negedge scanclk) begin
        if (phase_en === 1'b1) begin
            if (!pe_prev) pe_cnt = pe_cnt + 1;
            run = run + 1;
            if (cntsel !== exp_cs || updn !== exp_ud)
                stab_bad = stab_bad + 1;
            last_pe_cyc = cyc;
            last_pe_cs = cntsel;
            last_pe_ud = updn;
        end else if (pe_prev) begin
            if (run != 2) width_bad = width_bad + 1;
            run = 0;
        end
        pe_prev = (phase_en === 1'b1);
    end

    task automatic send(input logic [4:0] cs, input logic ud,
                        input logic [7:0] st, input bit hold,
                        output int acc);
        bus.req_cntsel = cs;
        bus.req_updn = ud;
        bus.req_steps = st;
        bus.req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 3000; i++) begin
            if (bus.req_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge scanclk);
        end
        checks++;
        if (acc < 0) $display("FAIL accept: no req_ready, need accept within 3000");
        else passed++;
        @(negedge scanclk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int dc);
        dc = -1;
        for (int i = 0; i < bound; i++) begin
            if (bus.done === 1'b1) begin
                dc = cyc;
                break;
            end
            @(negedge scanclk);
        end
        checks++;
        if (dc < 0) $display("FAIL done_seen: no done within %0d cycles", bound);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pll_locked = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_cntsel = '0;
        bus.req_updn = 1'b0;
        bus.req_steps = '0;
        repeat (2) @(negedge scanclk);
        checks++;
        if ({phase_en, updn, cntsel} !== 7'd0)
            $display("FAIL rst_pll: got %b, need 0", {phase_en, updn, cntsel});
        else passed++;
        checks++;
        if ({bus.busy, bus.done, bus.req_ready} !== 3'b000)
            $display("FAIL rst_ctl: got %b, need 000", {bus.busy, bus.done, bus.req_ready});
        else passed++;
        checks++;
        if (bus.err_code !== ERR_NONE || bus.steps_done !== 8'd0)
            $display("FAIL rst_stat: err %0d steps %0d, need 0 0", bus.err_code, bus.steps_done);
        else passed++;
        rst_n = 1'b1;
        repeat (3) @(negedge scanclk);
        checks++;
        if (bus.req_ready !== 1'b1)
            $display("FAIL rst_ready: got %b, need 1", bus.req_ready);
        else passed++;
    endtask

    task automatic test_three_steps();
        int acc, dc, p0, w0, s0;
        p0 = pe_cnt; w0 = width_bad; s0 = stab_bad;
        exp_cs = 5'd0; exp_ud = 1'b1;
        send(5'd0, 1'b1, 8'd3, 1'b0, acc);
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL t1_busy: got %b, need 1", bus.busy);
        else passed++;
        wait_done(300, dc);
        @(negedge scanclk);
        checks++;
        if (pe_cnt - p0 != 3) $display("FAIL t1_pulses: got %0d, need 3", pe_cnt - p0);
        else passed++;
        checks++;
        if (width_bad != w0) $display("FAIL t1_width: %0d pulses not 2 cycles wide, need 0", width_bad - w0);
        else passed++;
        checks++;
        if (stab_bad != s0) $display("FAIL t1_stable: %0d unstable samples, need 0", stab_bad - s0);
        else passed++;
        checks++;
        if (bus.steps_done !== 8'd3 || bus.err_code !== ERR_NONE)
            $display("FAIL t1_status: steps %0d err %0d, need 3 0", bus.steps_done, bus.err_code);
        else passed++;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL t1_pulse1: done %b busy %b, need 0 0", bus.done, bus.busy);
        else passed++;
    endtask

    task automatic test_zero_steps();
        int acc, dc, p0;
        p0 = pe_cnt;
        send(5'd2, 1'b0, 8'd0, 1'b0, acc);
        wait_done(20, dc);
        checks++;
        if (dc != acc + 2) $display("FAIL t2_latency: got %0d, need %0d", dc - acc, 2);
        else passed++;
        checks++;
        if (pe_cnt != p0 || bus.steps_done !== 8'd0 || bus.err_code !== ERR_NONE)
            $display("FAIL t2_status: pulses %0d steps %0d err %0d, need 0 0 0",
                     pe_cnt - p0, bus.steps_done, bus.err_code);
        else passed++;
    endtask

    task automatic test_timeout();
        int acc, dc;
        model_on = 1'b0;
        exp_cs = 5'd3; exp_ud = 1'b0;
        send(5'd3, 1'b0, 8'd2, 1'b0, acc);
        wait_done(1200, dc);
        checks++;
        if (dc != acc + 1029) $display("FAIL t3_latency: got %0d, need 1029", dc - acc);
        else passed++;
        checks++;
        if (bus.err_code !== ERR_TIMEOUT || bus.steps_done !== 8'd0)
            $display("FAIL t3_status: err %0d steps %0d, need 1 0", bus.err_code, bus.steps_done);
        else passed++;
        model_on = 1'b1;
        repeat (10) @(negedge scanclk);
    endtask

    task automatic test_lock_loss();
        int acc, dc, p0, drop, rdy;
        p0 = pe_cnt;
        exp_cs = 5'd6; exp_ud = 1'b1;
        send(5'd6, 1'b1, 8'd5, 1'b0, acc);
        drop = -1;
        for (int i = 0; i < 200; i++) begin
            if (bus.steps_done === 8'd2) begin
                drop = cyc;
                break;
            end
            @(negedge scanclk);
        end
        pll_locked = 1'b0;
        checks++;
        if (drop < 0) $display("FAIL t4_reach2: steps_done never 2, need 2");
        else passed++;
        wait_done(50, dc);
        checks++;
        if (last_pe_cyc > drop + 3) $display("FAIL t4_pe_drop: phase_en at %0d, need <= %0d", last_pe_cyc, drop + 3);
        else passed++;
        checks++;
        if (bus.err_code !== ERR_LOCK || bus.steps_done !== 8'd2 || pe_cnt - p0 != 2)
            $display("FAIL t4_status: err %0d steps %0d pulses %0d, need 2 2 2",
                     bus.err_code, bus.steps_done, pe_cnt - p0);
        else passed++;
        rdy = 0;
        repeat (6) begin
            @(negedge scanclk);
            if (bus.req_ready !== 1'b0) rdy++;
        end
        checks++;
        if (rdy != 0) $display("FAIL t4_ready_low: ready high %0d cycles, need 0", rdy);
        else passed++;
        pll_locked = 1'b1;
        repeat (3) @(negedge scanclk);
        checks++;
        if (bus.req_ready !== 1'b1) $display("FAIL t4_ready_back: got %b, need 1", bus.req_ready);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int acc_a, acc_b, dc, da, p0;
        bit seen_a, early;
        checks++;
        if (bus.err_code !== ERR_LOCK) $display("FAIL t5_err_held: got %0d, need 2", bus.err_code);
        else passed++;
        send(5'd4, 1'b1, 8'd1, 1'b1, acc_a);
        bus.req_cntsel = 5'd1;
        bus.req_updn = 1'b0;
        bus.req_steps = 8'd1;
        checks++;
        if (bus.err_code !== ERR_NONE || bus.req_ready !== 1'b0)
            $display("FAIL t5_accept_a: err %0d ready %b, need 0 0", bus.err_code, bus.req_ready);
        else passed++;
        seen_a = 0; early = 0; acc_b = -1; da = -1;
        for (int i = 0; i < 300; i++) begin
            if (bus.done === 1'b1) begin
                seen_a = 1;
                da = cyc;
            end
            if (bus.req_ready === 1'b1) begin
                if (!seen_a) early = 1;
                acc_b = cyc;
                break;
            end
            @(negedge scanclk);
        end
        p0 = pe_cnt;
        @(negedge scanclk);
        bus.req_valid = 1'b0;
        checks++;
        if (early || acc_b < 0 || acc_b < da)
            $display("FAIL t5_order: accept_b %0d done_a %0d, need accept after done", acc_b, da);
        else passed++;
        wait_done(100, dc);
        checks++;
        if (pe_cnt - p0 != 1 || last_pe_cs !== 5'd1 || last_pe_ud !== 1'b0)
            $display("FAIL t5_pulse: pulses %0d cntsel %0d updn %b, need 1 1 0",
                     pe_cnt - p0, last_pe_cs, last_pe_ud);
        else passed++;
        checks++;
        if (bus.steps_done !== 8'd1 || bus.err_code !== ERR_NONE)
            $display("FAIL t5_status: steps %0d err %0d, need 1 0", bus.steps_done, bus.err_code);
        else passed++;
    endtask

    task automatic test_reset_mid_step();
        int acc, rise, p0;
        exp_cs = 5'd7; exp_ud = 1'b1;
        send(5'd7, 1'b1, 8'd3, 1'b0, acc);
        rise = -1;
        for (int i = 0; i < 50; i++) begin
            if (phase_en === 1'b1) begin
                rise = cyc;
                break;
            end
            @(negedge scanclk);
        end
        repeat (6) @(negedge scanclk);
        checks++;
        if (rise < 0 || bus.busy !== 1'b1 || bus.steps_done !== 8'd0)
            $display("FAIL t6_pre: rise %0d busy %b steps %0d, need busy 1 steps 0",
                     rise, bus.busy, bus.steps_done);
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({phase_en, updn, cntsel} !== 7'd0)
            $display("FAIL t6_pll: got %b, need 0", {phase_en, updn, cntsel});
        else passed++;
        checks++;
        if ({bus.busy, bus.done, bus.err_code, bus.steps_done, bus.req_ready} !== 13'd0)
            $display("FAIL t6_stat: busy %b done %b err %0d steps %0d ready %b, need all 0",
                     bus.busy, bus.done, bus.err_code, bus.steps_done, bus.req_ready);
        else passed++;
        @(negedge scanclk);
        rst_n = 1'b1;
        p0 = pe_cnt;
        repeat (20) @(negedge scanclk);
        checks++;
        if (bus.req_ready !== 1'b1 || pe_cnt != p0 || bus.busy !== 1'b0)
            $display("FAIL t6_idle: ready %b pulses %0d busy %b, need 1 0 0",
                     bus.req_ready, pe_cnt - p0, bus.busy);
        else passed++;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        @(negedge scanclk);
        test_reset();
        test_three_steps();
        test_zero_steps();
        test_timeout();
        test_lock_loss();
        test_back_to_back();
        test_reset_mid_step();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
